mem_access_unit: RTL
====================

# mem_access_unit

Memory access unit between the multicycle controller/datapath and the external memory port. It turns the controller's MemRead/MemWrite/IRWrite/IorD strobes into a registered req/ack transaction with bounded wait. It captures read data into the instruction register (IR) and the memory data register (MDR), and reports completion (`done`), occupancy (`busy`) and sticky faults.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 15: maximum number of cycles `mem_req` is held without `mem_ack` before a fault; must be ≥ 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `MemRead` in 1: read strobe from controller.
- `MemWrite` in 1: write strobe from controller.
- `IRWrite` in 1: load read data into IR.
- `IorD` in 1: address select, 0 = `pc`, 1 = `alu_out`.
- `pc` in ADDR_W: program counter.
- `alu_out` in ADDR_W: ALUOut register, data address.
- `wdata` in DATA_W: store data (B register).
- `mem_req` out 1: memory request.
- `mem_we` out 1: write enable, valid while `mem_req` is high.
- `mem_addr` out ADDR_W: request address.
- `mem_wdata` out DATA_W: request write data.
- `mem_rdata` in DATA_W: read data, valid with `mem_ack`.
- `mem_ack` in 1: transaction complete.
- `ir` out DATA_W: instruction register.
- `mdr` out DATA_W: memory data register.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle completion pulse.
- `fault_code` out 2: 00 none, 01 misaligned, 10 timeout, 11 read/write conflict. Sticky.

## Operation
- State machine: IDLE, ACCESS, FAULT.
- Request detection:
  - `strobe = MemRead | MemWrite`.
  - Registered `strobe_q` gives edge detection; a request is accepted only in IDLE on the rising edge (`strobe & ~strobe_q`).
  - A level held across `done` never retriggers.
- On acceptance in IDLE, checks in priority order:
  - `MemRead & MemWrite` → `fault_code` = 11, go to FAULT.
  - Selected address[1:0] ≠ 0 → `fault_code` = 01, go to FAULT.
  - Otherwise latch `mem_addr` (`IorD ? alu_out : pc`), `mem_we = MemWrite`, `mem_wdata = wdata`, and an IR-load flag `= IRWrite & MemRead`. Clear the wait counter and go to ACCESS.
- In ACCESS:
  - `mem_req` = 1 and `busy` = 1.
  - On `mem_ack`:
    - Read: `mdr <= mem_rdata`; if the IR-load flag is set, also `ir <= mem_rdata`.
    - Write: `ir` and `mdr` unchanged.
    - Go to IDLE; `done` = 1 the next cycle.
  - Without `mem_ack`: counter increments. When the counter equals TIMEOUT−1 at an edge with no ack → `fault_code` = 10, go to FAULT.
  - `mem_ack` on the same edge as the timeout wins (completes normally).
- FAULT:
  - `mem_req` = 0, `busy` = 0.
  - All strobes ignored; exit only by reset.
- `mem_ack` outside ACCESS is ignored.
- Counter width is `$clog2(TIMEOUT+1)` and saturates, so it never wraps.

## Timing
- All outputs are registered.
- Reset values:
  - `mem_req`, `mem_we`, `busy`, `done` = 0.
  - `mem_addr`, `mem_wdata`, `ir`, `mdr` = 0 (`ir` = 0 decodes as NOOP).
  - `fault_code` = 00, `strobe_q` = 0, state IDLE.
- Reset asserted mid-ACCESS drops `mem_req` immediately (asynchronous) and abandons the transaction.
- Latency:
  - Strobe rising at edge E0 → `mem_req` and `busy` high in cycle E0..E1.
  - Ack sampled at edge Ek → `ir`/`mdr` valid, `mem_req`/`busy` low, and `done` high for exactly cycle Ek..Ek+1.
  - Minimum is ack in the first request cycle: 2 cycles strobe-to-done.
- `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` stay stable from assertion until the ack edge.
- `done` and `busy` are never high together.

## Structure
- Shared package `cpu_pkg` holds:
  - The `mau_state_t` enum (IDLE/ACCESS/FAULT).
  - The fault-code constants `FLT_NONE`, `FLT_MISALIGN`, `FLT_TIMEOUT`, `FLT_CONFLICT`.
  - The width constants `WORD_W` and `ADDR_W`.
- One natural sub-module, `mem_wait_timer`: a saturating counter with clear/enable inputs and an `expired` output at TIMEOUT−1, parameterised by TIMEOUT.

## Test plan
- Fetch: `IorD`=0, `pc`=0x40, `MemRead`+`IRWrite` rise, ack in the first request cycle with `mem_rdata`=0x5C000007 → `mem_addr`=0x40, `mem_we`=0, `ir`=`mdr`=0x5C000007, single `done` pulse, 2-cycle latency.
- Load with wait: `IorD`=1, `alu_out`=0x100, ack on the 4th request cycle with 0xDEADBEEF → `mdr`=0xDEADBEEF, `ir` unchanged, `busy` high 4 cycles, `done` 1 cycle.
- Store: `MemWrite`, `alu_out`=0x200, `wdata`=0x12345678, ack after 2 cycles → `mem_we`=1, `mem_wdata`=0x12345678, `mdr`/`ir` unchanged. Holding `MemWrite` high after `done` issues no second request.
- Misaligned and conflict: `alu_out`=0x102 → `fault_code`=01 with no `mem_req`. After reset, `MemRead`+`MemWrite` together → `fault_code`=11. In both cases later strobes are ignored.
- Timeout: TIMEOUT=4, no ack → `mem_req` high exactly 4 cycles, then `fault_code`=10. Variant with ack on the 4th cycle → normal completion, no fault.
- Reset mid-access: `reset`=0 during ACCESS → `mem_req`=0 immediately; all outputs at reset values; the next clean read completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle CPU memory path.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FAULT  = 2'd2
  } mau_state_t;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FLT_CONFLICT = 2'b11;

  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// External memory port: request/ack handshake with address, write data and read data.
interface mem_access_unit_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::WORD_W
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_access_unit_timer.sv
// Saturating wait counter; expired flags the last permitted request cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != CNT_W'(TIMEOUT))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expired = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Turns controller MemRead/MemWrite/IRWrite/IorD strobes into one bounded req/ack
// memory transaction, capturing read data into IR/MDR and latching sticky faults.
module mem_access_unit #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int DATA_W  = cpu_pkg::WORD_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IRWrite,
  input  logic              IorD,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  mem_access_unit_if.master mem,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fault_code
);

  cpu_pkg::mau_state_t r_state, w_state_next;

  logic              r_mem_req, w_req_next;
  logic              r_mem_we, w_we_next;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_next;
  logic [DATA_W-1:0] r_mem_wdata, w_wdata_next;
  logic [DATA_W-1:0] r_ir, w_ir_next;
  logic [DATA_W-1:0] r_mdr, w_mdr_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic [1:0]        r_fault, w_fault_next;
  logic              r_ir_load, w_ir_load_next;
  logic              r_strobe_q;

  logic              w_strobe, w_accept, w_tmr_clear, w_tmr_enable, w_expired;
  logic [ADDR_W-1:0] w_sel_addr;

  assign w_strobe   = MemRead | MemWrite;
  // Only a fresh rising strobe starts a transaction, so a level held past done is inert.
  assign w_accept   = (r_state == cpu_pkg::IDLE) && w_strobe && !r_strobe_q;
  assign w_sel_addr = IorD ? alu_out : pc;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_tmr_clear),
    .enable  (w_tmr_enable),
    .expired (w_expired)
  );

  always_comb begin
    w_state_next   = r_state;
    w_req_next     = r_mem_req;
    w_we_next      = r_mem_we;
    w_addr_next    = r_mem_addr;
    w_wdata_next   = r_mem_wdata;
    w_ir_next      = r_ir;
    w_mdr_next     = r_mdr;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_fault_next   = r_fault;
    w_ir_load_next = r_ir_load;
    w_tmr_clear    = 1'b0;
    w_tmr_enable   = 1'b0;
    case (r_state)
      cpu_pkg::IDLE: begin
        if (w_accept) begin
          if (MemRead && MemWrite) begin
            w_fault_next = cpu_pkg::FLT_CONFLICT;
            w_state_next = cpu_pkg::FAULT;
          end else if (!cpu_pkg::word_aligned(w_sel_addr[1:0])) begin
            w_fault_next = cpu_pkg::FLT_MISALIGN;
            w_state_next = cpu_pkg::FAULT;
          end else begin
            w_addr_next    = w_sel_addr;
            w_we_next      = MemWrite;
            w_wdata_next   = wdata;
            w_ir_load_next = IRWrite & MemRead;
            w_req_next     = 1'b1;
            w_busy_next    = 1'b1;
            w_tmr_clear    = 1'b1;
            w_state_next   = cpu_pkg::ACCESS;
          end
        end
      end
      cpu_pkg::ACCESS: begin
        // Ack is checked first so an ack on the expiry edge still completes.
        if (mem.mem_ack) begin
          if (!r_mem_we) begin
            w_mdr_next = mem.mem_rdata;
            if (r_ir_load) begin
              w_ir_next = mem.mem_rdata;
            end
          end
          w_req_next   = 1'b0;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = cpu_pkg::IDLE;
        end else if (w_expired) begin
          w_fault_next = cpu_pkg::FLT_TIMEOUT;
          w_req_next   = 1'b0;
          w_busy_next  = 1'b0;
          w_state_next = cpu_pkg::FAULT;
        end else begin
          w_tmr_enable = 1'b1;
        end
      end
      cpu_pkg::FAULT: begin
        w_req_next  = 1'b0;
        w_busy_next = 1'b0;
      end
      default: begin
        w_state_next = cpu_pkg::IDLE;
        w_req_next   = 1'b0;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= cpu_pkg::IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ir        <= '0;
      r_mdr       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= cpu_pkg::FLT_NONE;
      r_ir_load   <= 1'b0;
      r_strobe_q  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mem_req   <= w_req_next;
      r_mem_we    <= w_we_next;
      r_mem_addr  <= w_addr_next;
      r_mem_wdata <= w_wdata_next;
      r_ir        <= w_ir_next;
      r_mdr       <= w_mdr_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_fault     <= w_fault_next;
      r_ir_load   <= w_ir_load_next;
      r_strobe_q  <= w_strobe;
    end
  end

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign ir            = r_ir;
  assign mdr           = r_mdr;
  assign busy          = r_busy;
  assign done          = r_done;
  assign fault_code    = r_fault;

endmodule
